// File: rtl/syncram_dual_be_pkg.sv
// Shared constants, clear-FSM encoding and the byte-lane merge helper for syncram_dual_be.
package syncram_dual_be_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;
    localparam int unsigned RDW_NO_CHANGE   = 2;

    // Merge helper works on a fixed wide word; callers cast in and out.
    localparam int unsigned MERGE_MAX_W = 256;
    localparam int unsigned MERGE_IDX_W = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] new_w,
        input logic [MERGE_MAX_W-1:0] be,
        input int unsigned            byte_w
    );
        logic [MERGE_MAX_W-1:0] merged;
        logic [MERGE_IDX_W-1:0] lane;
        merged = old_w;
        for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
            lane = MERGE_IDX_W'(i / byte_w);
            if (be[lane]) merged[MERGE_IDX_W'(i)] = new_w[MERGE_IDX_W'(i)];
        end
        return merged;
    endfunction

endpackage

// File: rtl/syncram_dual_be_if.sv
// Bus bundle for both RAM ports plus the shared status outputs.
interface syncram_dual_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  busy;
    logic                  collision;

    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] datain_a;
    logic [NB-1:0]         be_a;
    logic                  we_a;
    logic                  re_a;
    logic [DATA_WIDTH-1:0] dataout_a;
    logic                  valid_a;

    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] datain_b;
    logic [NB-1:0]         be_b;
    logic                  we_b;
    logic                  re_b;
    logic [DATA_WIDTH-1:0] dataout_b;
    logic                  valid_b;

    modport master (
        output addr_a, datain_a, be_a, we_a, re_a,
        output addr_b, datain_b, be_b, we_b, re_b,
        input  dataout_a, valid_a, dataout_b, valid_b, busy, collision
    );

    modport slave (
        input  addr_a, datain_a, be_a, we_a, re_a,
        input  addr_b, datain_b, be_b, we_b, re_b,
        output dataout_a, valid_a, dataout_b, valid_b, busy, collision
    );

endinterface

// File: rtl/syncram_dual_be_port.sv
// One RAM port's read path: read-during-write selection, optional output stage, valid strobe.
module syncram_dual_be_port
    import syncram_dual_be_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_en,
    input  logic                             i_we,
    input  logic                             i_re,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]            i_din,
    input  logic [DATA_WIDTH-1:0]            i_old,
    output logic [DATA_WIDTH-1:0]            o_dout,
    output logic                             o_valid
);

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0]            old_w,
        input logic [DATA_WIDTH-1:0]            new_w,
        input logic [DATA_WIDTH/BYTE_WIDTH-1:0] be
    );
        return DATA_WIDTH'(lane_merge(MERGE_MAX_W'(old_w), MERGE_MAX_W'(new_w),
                                      MERGE_MAX_W'(be), BYTE_WIDTH));
    endfunction

    logic                  w_present;
    logic [DATA_WIDTH-1:0] w_word;

    // Decide whether this cycle's access presents a word, and which one.
    always_comb begin
        w_present = 1'b0;
        w_word    = i_old;
        if (i_en && i_we) begin
            w_present = (RDW_MODE != RDW_NO_CHANGE);
            if (RDW_MODE == RDW_WRITE_FIRST) w_word = merge_word(i_old, i_din, i_be);
        end else if (i_en && i_re) begin
            w_present = 1'b1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  r_s1_valid;
            logic [DATA_WIDTH-1:0] r_s1_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    o_valid    <= 1'b0;
                    o_dout     <= '0;
                end else begin
                    r_s1_valid <= w_present;
                    if (w_present) r_s1_data <= w_word;
                    o_valid <= r_s1_valid;
                    if (r_s1_valid) o_dout <= r_s1_data;
                end
            end
        end else begin : g_noreg
            always_ff @(posedge clk) begin
                if (reset) begin
                    o_valid <= 1'b0;
                    o_dout  <= '0;
                end else begin
                    o_valid <= w_present;
                    if (w_present) o_dout <= w_word;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/syncram_dual_be.sv
// True dual-port byte-enable RAM with collision flag and post-reset clear sequencer.
module syncram_dual_be
    import syncram_dual_be_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 10,
    parameter int unsigned           BYTE_WIDTH     = 8,
    parameter int unsigned           RDW_MODE       = 0,
    parameter int unsigned           OUT_REG        = 0,
    parameter int unsigned           CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset,
    syncram_dual_be_if.slave  bus
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         be
    );
        return DATA_WIDTH'(lane_merge(MERGE_MAX_W'(old_w), MERGE_MAX_W'(new_w),
                                      MERGE_MAX_W'(be), BYTE_WIDTH));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    clr_state_t            r_state;
    clr_state_t            w_state_nx;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nx;
    logic                  r_busy;
    logic                  r_collision;

    logic                  w_en;
    logic                  w_we_a;
    logic                  w_we_b;
    logic                  w_same;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic [DATA_WIDTH-1:0] w_word_a;
    logic [DATA_WIDTH-1:0] w_word_b;

    // Clear sequencer state register; busy mirrors "next cycle is still clearing".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_busy  <= (w_state_nx == ST_CLEAR);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        if (r_state == ST_CLEAR) begin
            w_ptr_nx = r_ptr + ADDR_WIDTH'(1);
            if (r_ptr == '1) w_state_nx = ST_READY;
        end
    end

    assign w_en      = !r_busy && !reset;
    assign w_we_a    = w_en && bus.we_a;
    assign w_we_b    = w_en && bus.we_b;
    assign w_old_a   = r_mem[bus.addr_a];
    assign w_old_b   = r_mem[bus.addr_b];
    assign w_collide = w_we_a && w_we_b && w_same && (|(bus.be_a & bus.be_b));

    // Same-address writes fold port B's lanes in first so port A wins on overlap.
    always_comb begin
        w_same   = (bus.addr_a == bus.addr_b);
        w_word_b = merge_word(w_old_b, bus.datain_b, bus.be_b);
        w_word_a = merge_word((w_same && w_we_b) ? w_word_b : w_old_a, bus.datain_a, bus.be_a);
    end

    always_ff @(posedge clk) begin
        if (!reset && r_state == ST_CLEAR) r_mem[r_ptr] <= CLEAR_VALUE;
        if (w_we_b && !(w_we_a && w_same)) r_mem[bus.addr_b] <= w_word_b;
        if (w_we_a) r_mem[bus.addr_a] <= w_word_a;
    end

    always_ff @(posedge clk) begin
        if (reset) r_collision <= 1'b0;
        else       r_collision <= w_collide;
    end

    assign bus.busy      = r_busy;
    assign bus.collision = r_collision;

    syncram_dual_be_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .RDW_MODE   (RDW_MODE),
        .OUT_REG    (OUT_REG)
    ) u_port_a (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en),
        .i_we    (bus.we_a),
        .i_re    (bus.re_a),
        .i_be    (bus.be_a),
        .i_din   (bus.datain_a),
        .i_old   (w_old_a),
        .o_dout  (bus.dataout_a),
        .o_valid (bus.valid_a)
    );

    syncram_dual_be_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .RDW_MODE   (RDW_MODE),
        .OUT_REG    (OUT_REG)
    ) u_port_b (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en),
        .i_we    (bus.we_b),
        .i_re    (bus.re_b),
        .i_be    (bus.be_b),
        .i_din   (bus.datain_b),
        .i_old   (w_old_b),
        .o_dout  (bus.dataout_b),
        .o_valid (bus.valid_b)
    );

endmodule

// File: tb/tb_syncram_dual_be.sv
// Bench: three RAM configurations (read-first, write-first+out-reg, no-change) on one shared stimulus.
module tb_syncram_dual_be;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] CV    = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  t_addr_a, t_addr_b, t_be_a, t_be_b;
    logic [31:0] t_din_a, t_din_b;
    logic        t_we_a, t_we_b, t_re_a, t_re_b;

    logic [31:0] q_dout_a [3];
    logic [31:0] q_dout_b [3];
    logic [2:0]  q_valid_a, q_valid_b, q_busy, q_coll;

    int n_checks = 0;
    int n_err    = 0;

    // k = RDW mode; instance 1 also carries the output register.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        syncram_dual_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8)) bus ();
        assign bus.addr_a   = t_addr_a;
        assign bus.datain_a = t_din_a;
        assign bus.be_a     = t_be_a;
        assign bus.we_a     = t_we_a;
        assign bus.re_a     = t_re_a;
        assign bus.addr_b   = t_addr_b;
        assign bus.datain_b = t_din_b;
        assign bus.be_b     = t_be_b;
        assign bus.we_b     = t_we_b;
        assign bus.re_b     = t_re_b;
        assign q_dout_a[k]  = bus.dataout_a;
        assign q_dout_b[k]  = bus.dataout_b;
        assign q_valid_a[k] = bus.valid_a;
        assign q_valid_b[k] = bus.valid_b;
        assign q_busy[k]    = bus.busy;
        assign q_coll[k]    = bus.collision;

        syncram_dual_be #(
            .DATA_WIDTH     (32),
            .ADDR_WIDTH     (4),
            .BYTE_WIDTH     (8),
            .RDW_MODE       (k),
            .OUT_REG        ((k == 1) ? 1 : 0),
            .CLEAR_ON_RESET (1),
            .CLEAR_VALUE    (CV)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_cnt     = 0;
    bit          m_busy    = 1'b1;
    bit          m_started = 1'b0;
    bit          m_coll    = 1'b0;
    logic [32:0] m_pend  [3][2];
    logic [31:0] m_dout  [3][2];
    bit          m_valid [3][2];

    function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] w;
        w = o;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = n[8*i +: 8];
        return w;
    endfunction

    // {presented, word} produced by one port request for the given read-during-write mode
    function automatic logic [32:0] req_result(input int mode, input bit en, input bit we, input bit re,
                                               input logic [31:0] old_w, input logic [31:0] din,
                                               input logic [3:0] be);
        if (!en) return {1'b0, old_w};
        if (we) begin
            if (mode == 2) return {1'b0, old_w};
            if (mode == 1) return {1'b1, apply_be(old_w, din, be)};
            return {1'b1, old_w};
        end
        if (re) return {1'b1, old_w};
        return {1'b0, old_w};
    endfunction

    always @(posedge clk) begin
        logic [31:0] old_a, old_b;
        logic [32:0] r, shown;
        bit          en;
        en    = !reset && !m_busy;
        old_a = m_mem[t_addr_a];
        old_b = m_mem[t_addr_b];
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                r = (p == 0) ? req_result(k, en, t_we_a, t_re_a, old_a, t_din_a, t_be_a)
                             : req_result(k, en, t_we_b, t_re_b, old_b, t_din_b, t_be_b);
                if (reset) begin
                    m_pend[k][p]  = '0;
                    m_dout[k][p]  = '0;
                    m_valid[k][p] = 1'b0;
                end else begin
                    shown         = (k == 1) ? m_pend[k][p] : r;
                    m_pend[k][p]  = r;
                    m_valid[k][p] = shown[32];
                    if (shown[32]) m_dout[k][p] = shown[31:0];
                end
            end
        end
        m_coll = en && t_we_a && t_we_b && (t_addr_a == t_addr_b) && ((t_be_a & t_be_b) != 4'b0);
        if (!reset && m_busy && m_cnt < DEPTH) m_mem[m_cnt] = CV;
        if (en && t_we_b) m_mem[t_addr_b] = apply_be(m_mem[t_addr_b], t_din_b, t_be_b);
        if (en && t_we_a) m_mem[t_addr_a] = apply_be(m_mem[t_addr_a], t_din_a, t_be_a);
        if (reset) begin
            m_busy    = 1'b1;
            m_cnt     = 0;
            m_started = 1'b1;
        end else if (m_busy) begin
            m_cnt++;
            m_busy = (m_cnt < DEPTH);
        end
    end

    // Compare every instance against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (m_started) begin
            for (int k = 0; k < 3; k++) begin
                chk("busy",      k, q_busy[k],    m_busy);
                chk("collision", k, q_coll[k],    m_coll);
                chk("valid_a",   k, q_valid_a[k], m_valid[k][0]);
                chk("valid_b",   k, q_valid_b[k], m_valid[k][1]);
                chk("dataout_a", k, q_dout_a[k],  m_dout[k][0]);
                chk("dataout_b", k, q_dout_b[k],  m_dout[k][1]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        t_we_a = 1'b0; t_re_a = 1'b0; t_we_b = 1'b0; t_re_b = 1'b0;
        t_be_a = 4'h0; t_be_b = 4'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40 && q_busy[0] === 1'b1; i++) begin
            cycles++;
            tick(1);
        end
    endtask

    initial begin
        int          busy_cycles;
        logic [31:0] expd;
        reset = 1'b1;
        idle();
        t_addr_a = '0; t_addr_b = '0; t_din_a = '0; t_din_b = '0;
        tick(2);
        chk("reset_busy", 0, q_busy[0], 1'b1);
        chk("reset_dout", 0, q_dout_a[0], 32'h0);
        reset = 1'b0;

        // clear sequence length, then read back every address
        count_busy(busy_cycles);
        chk("clear_len", 0, busy_cycles, 16);
        for (int i = 0; i < 16; i++) begin
            t_re_a = 1'b1; t_addr_a = 4'(i);
            tick(1);
            chk("clear_val", i, q_dout_a[0], 32'hDEADBEEF);
            chk("clear_vld", i, q_valid_a[0], 1'b1);
        end
        idle(); tick(2);

        // byte-lane writes
        t_we_a = 1'b1; t_addr_a = 4'd3; t_din_a = 32'h11223344; t_be_a = 4'b1111; tick(1);
        t_din_a = 32'hAABBCCDD; t_be_a = 4'b0101; tick(1);
        idle(); t_re_b = 1'b1; t_addr_b = 4'd3; tick(1);
        chk("be_merge", 0, q_dout_b[0], 32'h11BB33DD);
        idle(); tick(2);

        // read-during-write on port A with old word 0
        t_we_a = 1'b1; t_addr_a = 4'd7; t_din_a = 32'h0; t_be_a = 4'hF; tick(1);
        t_din_a = 32'h12345678; t_re_a = 1'b1; tick(1);
        chk("rdw0_data",  0, q_dout_a[0],  32'h0);
        chk("rdw0_valid", 0, q_valid_a[0], 1'b1);
        chk("rdw2_data",  2, q_dout_a[2],  32'hDEADBEEF);
        chk("rdw2_valid", 2, q_valid_a[2], 1'b0);
        idle(); tick(1);
        chk("rdw1_data",  1, q_dout_a[1],  32'h12345678);
        chk("rdw1_valid", 1, q_valid_a[1], 1'b1);
        tick(2);

        // overlapping and disjoint same-address writes
        t_we_a = 1'b1; t_addr_a = 4'd5; t_din_a = 32'hAAAAAAAA; t_be_a = 4'b1111;
        t_we_b = 1'b1; t_addr_b = 4'd5; t_din_b = 32'hBBBBBBBB; t_be_b = 4'b1100;
        tick(1);
        chk("coll_pulse", 0, q_coll[0], 1'b1);
        idle(); tick(1);
        chk("coll_once", 0, q_coll[0], 1'b0);
        t_re_a = 1'b1; tick(1);
        chk("coll_data", 0, q_dout_a[0], 32'hAAAAAAAA);
        idle();
        t_we_a = 1'b1; t_be_a = 4'b0011; t_we_b = 1'b1; t_be_b = 4'b1100;
        tick(1);
        chk("disj_nocoll", 0, q_coll[0], 1'b0);
        idle(); t_re_a = 1'b1; tick(1);
        chk("disj_data", 0, q_dout_a[0], 32'hBBBBAAAA);
        idle(); tick(1);

        // streaming reads through the output register
        for (int i = 0; i < 3; i++) begin
            t_we_a = 1'b1; t_addr_a = 4'(i); t_din_a = 32'h10000000 + 32'(i); t_be_a = 4'hF;
            tick(1);
        end
        idle(); tick(3);
        for (int j = 0; j < 6; j++) begin
            idle();
            if (j < 4) begin t_re_b = 1'b1; t_addr_b = 4'(j); end
            tick(1);
            chk("stream_vld", j, q_valid_b[1], (j >= 1 && j <= 4) ? 1'b1 : 1'b0);
            if (j >= 1 && j <= 4) begin
                expd = (j == 4) ? 32'h11BB33DD : 32'h10000000 + 32'(j - 1);
                chk("stream_data", j, q_dout_b[1], expd);
            end
        end
        idle(); tick(1);

        // reset in the middle of a clear, with writes attempted while busy
        reset = 1'b1; tick(1); reset = 1'b0;
        tick(7);
        reset = 1'b1;
        t_we_a = 1'b1; t_addr_a = 4'd9;  t_din_a = 32'h12121212; t_be_a = 4'hF;
        t_we_b = 1'b1; t_addr_b = 4'd10; t_din_b = 32'h34343434; t_be_b = 4'hF;
        tick(1);
        reset = 1'b0;
        count_busy(busy_cycles);
        idle();
        chk("reclear_len", 0, busy_cycles, 16);
        t_re_a = 1'b1; t_addr_a = 4'd9; t_re_b = 1'b1; t_addr_b = 4'd10; tick(1);
        chk("busy_wr_a", 0, q_dout_a[0], 32'hDEADBEEF);
        chk("busy_wr_b", 0, q_dout_b[0], 32'hDEADBEEF);
        idle(); tick(1);

        // randomized traffic, model checked every cycle
        for (int c = 0; c < 500; c++) begin
            bit narrow;
            narrow   = ($urandom_range(0, 1) == 1);
            reset    = ($urandom_range(0, 299) == 0);
            t_addr_a = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            t_addr_b = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            t_din_a  = $urandom;
            t_din_b  = $urandom;
            t_be_a   = 4'($urandom_range(0, 15));
            t_be_b   = 4'($urandom_range(0, 15));
            t_we_a   = ($urandom_range(0, 2) == 0);
            t_we_b   = ($urandom_range(0, 2) == 0);
            t_re_a   = ($urandom_range(0, 1) == 0);
            t_re_b   = ($urandom_range(0, 1) == 0);
            tick(1);
        end
        reset = 1'b0;
        idle(); tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
